// File: rtl/cv32e40p_perm_fault_manager_ft_pkg.sv
// Shared types for the fault-tolerant permanent-fault manager: replica vector,
// clear-handshake FSM states and a helper for detecting newly latched faults.
package cv32e40p_ft_pkg;

   localparam int NUM_REPLICA = 4;

   typedef logic [NUM_REPLICA-1:0] replica_vec_t;

   typedef enum logic [1:0] {
      FM_RUN   = 2'd0,
      FM_CLEAR = 2'd1,
      FM_ACK   = 2'd2
   } fault_mgr_state_e;

   function automatic replica_vec_t newly_set(input replica_vec_t prev, input replica_vec_t nxt);
      return nxt & ~prev;
   endfunction

endpackage

// File: rtl/cv32e40p_perm_fault_manager_ft_if.sv
// Voter-side and software-side signals of the permanent-fault manager.
// Force inputs exist only when CV32E40P_FT_FAULT_INJECT_EN is defined.
interface cv32e40p_perm_fault_manager_ft_if
   import cv32e40p_ft_pkg::*;
#(
   parameter int CNT_W = 4
);

   logic                         alu_valid_i;
   replica_vec_t                 alu_mismatch_i;
   logic                         mult_valid_i;
   replica_vec_t                 mult_mismatch_i;
   logic                         clr_req_i;
   logic                         clr_ack_o;
   replica_vec_t                 permanent_faulty_alu_o;
   replica_vec_t                 permanent_faulty_mult_o;
   logic                         new_fault_o;
   logic [NUM_REPLICA*CNT_W-1:0] err_cnt_alu_o;
   logic [NUM_REPLICA*CNT_W-1:0] err_cnt_mult_o;
`ifdef CV32E40P_FT_FAULT_INJECT_EN
   replica_vec_t                 force_alu_i;
   replica_vec_t                 force_mult_i;
`endif

   modport master (
`ifdef CV32E40P_FT_FAULT_INJECT_EN
      output force_alu_i,
      output force_mult_i,
`endif
      output alu_valid_i,
      output alu_mismatch_i,
      output mult_valid_i,
      output mult_mismatch_i,
      output clr_req_i,
      input  clr_ack_o,
      input  permanent_faulty_alu_o,
      input  permanent_faulty_mult_o,
      input  new_fault_o,
      input  err_cnt_alu_o,
      input  err_cnt_mult_o
   );

   modport slave (
`ifdef CV32E40P_FT_FAULT_INJECT_EN
      input  force_alu_i,
      input  force_mult_i,
`endif
      input  alu_valid_i,
      input  alu_mismatch_i,
      input  mult_valid_i,
      input  mult_mismatch_i,
      input  clr_req_i,
      output clr_ack_o,
      output permanent_faulty_alu_o,
      output permanent_faulty_mult_o,
      output new_fault_o,
      output err_cnt_alu_o,
      output err_cnt_mult_o
   );

endinterface

// File: rtl/cv32e40p_fault_counter_ft.sv
// Leaky-bucket error counters, decay window and sticky permanent-fault bits for
// one functional-unit class. Optional force input under CV32E40P_FT_FAULT_INJECT_EN.
module cv32e40p_fault_counter_ft
   import cv32e40p_ft_pkg::*;
#(
   parameter int CNT_W     = 4,
   parameter int THRESHOLD = 8,
   parameter int WINDOW    = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
`ifdef CV32E40P_FT_FAULT_INJECT_EN
   input  replica_vec_t                 force_perm,
`endif
   input  logic                         valid,
   input  replica_vec_t                 mismatch,
   input  logic                         suspend,
   input  logic                         clear,
   output logic [NUM_REPLICA*CNT_W-1:0] cnt_packed,
   output replica_vec_t                 perm,
   output replica_vec_t                 new_set
);

   localparam int               WIN_W    = $clog2(WINDOW);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_THR  = CNT_W'(THRESHOLD);

   logic [CNT_W-1:0] cnt_r     [NUM_REPLICA];
   logic [CNT_W-1:0] cnt_nxt_s [NUM_REPLICA];
   replica_vec_t     perm_r;
   replica_vec_t     perm_nxt_s;
   replica_vec_t     inc_s;
   logic [WIN_W-1:0] win_r;
   logic [WIN_W-1:0] win_nxt_s;
   logic             decay_s;

   assign inc_s = mismatch & ~perm_r & {NUM_REPLICA{valid}};

   // Next-state of window, counters and permanent bits; a simultaneous hit and decay cancel out.
   always_comb begin
      decay_s    = 1'b0;
      win_nxt_s  = win_r;
      perm_nxt_s = perm_r;
      for (int i = 0; i < NUM_REPLICA; i++) begin
         cnt_nxt_s[i] = cnt_r[i];
      end
      if (clear) begin
         win_nxt_s  = '0;
         perm_nxt_s = '0;
         for (int i = 0; i < NUM_REPLICA; i++) begin
            cnt_nxt_s[i] = '0;
         end
      end else if (suspend) begin
         win_nxt_s  = win_r;
         perm_nxt_s = perm_r;
      end else begin
         if (valid) begin
            decay_s   = (win_r == WIN_LAST);
            win_nxt_s = decay_s ? '0 : win_r + WIN_W'(1);
         end else begin
            decay_s   = 1'b0;
            win_nxt_s = win_r;
         end
         for (int i = 0; i < NUM_REPLICA; i++) begin
            if (perm_r[i]) begin
               cnt_nxt_s[i]  = cnt_r[i];
               perm_nxt_s[i] = 1'b1;
            end else begin
               if (inc_s[i] && decay_s) begin
                  cnt_nxt_s[i] = cnt_r[i];
               end else if (inc_s[i]) begin
                  cnt_nxt_s[i] = (cnt_r[i] == CNT_MAX) ? cnt_r[i] : cnt_r[i] + CNT_W'(1);
               end else if (decay_s && (cnt_r[i] != '0)) begin
                  cnt_nxt_s[i] = cnt_r[i] - CNT_W'(1);
               end else begin
                  cnt_nxt_s[i] = cnt_r[i];
               end
               perm_nxt_s[i] = (cnt_nxt_s[i] >= CNT_THR);
            end
         end
`ifdef CV32E40P_FT_FAULT_INJECT_EN
         perm_nxt_s = perm_nxt_s | force_perm;
`endif
      end
   end

   // State registers for this class.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_r  <= '0;
         perm_r <= '0;
         for (int i = 0; i < NUM_REPLICA; i++) begin
            cnt_r[i] <= '0;
         end
      end else begin
         win_r  <= win_nxt_s;
         perm_r <= perm_nxt_s;
         for (int i = 0; i < NUM_REPLICA; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_REPLICA; g++) begin : g_pack
      assign cnt_packed[g*CNT_W +: CNT_W] = cnt_r[g];
   end

   assign perm    = perm_r;
   assign new_set = newly_set(perm_r, perm_nxt_s);

endmodule

// File: rtl/cv32e40p_perm_fault_manager_ft.sv
// Permanent-fault manager: per-class error tracking, software clear handshake and
// new-fault pulse. Define CV32E40P_FT_FAULT_INJECT_EN to add the force inputs.
module cv32e40p_perm_fault_manager_ft
   import cv32e40p_ft_pkg::*;
#(
   parameter int CNT_W     = 4,
   parameter int THRESHOLD = 8,
   parameter int WINDOW    = 16
) (
   input logic                            clk,
   input logic                            rst_n,
   cv32e40p_perm_fault_manager_ft_if.slave bus
);

   fault_mgr_state_e state_r;
   logic             clr_ack_r;
   logic             new_fault_r;
   logic             suspend_s;
   logic             clear_s;
   replica_vec_t     alu_perm_s;
   replica_vec_t     mult_perm_s;
   replica_vec_t     alu_new_s;
   replica_vec_t     mult_new_s;

   assign suspend_s = (state_r != FM_RUN);
   assign clear_s   = (state_r == FM_CLEAR);

   cv32e40p_fault_counter_ft #(
      .CNT_W     (CNT_W),
      .THRESHOLD (THRESHOLD),
      .WINDOW    (WINDOW)
   ) u_alu_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef CV32E40P_FT_FAULT_INJECT_EN
      .force_perm (bus.force_alu_i),
`endif
      .valid      (bus.alu_valid_i),
      .mismatch   (bus.alu_mismatch_i),
      .suspend    (suspend_s),
      .clear      (clear_s),
      .cnt_packed (bus.err_cnt_alu_o),
      .perm       (alu_perm_s),
      .new_set    (alu_new_s)
   );

   cv32e40p_fault_counter_ft #(
      .CNT_W     (CNT_W),
      .THRESHOLD (THRESHOLD),
      .WINDOW    (WINDOW)
   ) u_mult_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef CV32E40P_FT_FAULT_INJECT_EN
      .force_perm (bus.force_mult_i),
`endif
      .valid      (bus.mult_valid_i),
      .mismatch   (bus.mult_mismatch_i),
      .suspend    (suspend_s),
      .clear      (clear_s),
      .cnt_packed (bus.err_cnt_mult_o),
      .perm       (mult_perm_s),
      .new_set    (mult_new_s)
   );

   // Clear handshake: CLEAR lasts one cycle, ACK holds until software drops the request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= FM_RUN;
         clr_ack_r <= 1'b0;
      end else begin
         case (state_r)
            FM_RUN: begin
               state_r   <= bus.clr_req_i ? FM_CLEAR : FM_RUN;
               clr_ack_r <= 1'b0;
            end
            FM_CLEAR: begin
               state_r   <= FM_ACK;
               clr_ack_r <= 1'b1;
            end
            FM_ACK: begin
               if (!bus.clr_req_i) begin
                  state_r   <= FM_RUN;
                  clr_ack_r <= 1'b0;
               end else begin
                  state_r   <= FM_ACK;
                  clr_ack_r <= 1'b1;
               end
            end
            default: begin
               state_r   <= FM_RUN;
               clr_ack_r <= 1'b0;
            end
         endcase
      end
   end

   // One pulse however many replicas of either class latch together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         new_fault_r <= 1'b0;
      end else begin
         new_fault_r <= |(alu_new_s | mult_new_s);
      end
   end

   assign bus.clr_ack_o               = clr_ack_r;
   assign bus.new_fault_o             = new_fault_r;
   assign bus.permanent_faulty_alu_o  = alu_perm_s;
   assign bus.permanent_faulty_mult_o = mult_perm_s;

endmodule

// File: tb/tb_cv32e40p_perm_fault_manager_ft.sv
// Directed plus randomized bench for cv32e40p_perm_fault_manager_ft against a
// rule-level reference model of the leaky-bucket counters and clear handshake.
module tb_cv32e40p_perm_fault_manager_ft;

   localparam int CNT_W      = 4;
   localparam int THRESHOLD  = 8;
   localparam int WINDOW     = 16;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;
   localparam int MODE_RUN   = 0;
   localparam int MODE_CLEAR = 1;
   localparam int MODE_ACK   = 2;

   logic clk;
   logic rst_n;

   cv32e40p_perm_fault_manager_ft_if #(.CNT_W(CNT_W)) bus ();

   cv32e40p_perm_fault_manager_ft #(
      .CNT_W     (CNT_W),
      .THRESHOLD (THRESHOLD),
      .WINDOW    (WINDOW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int m_cnt  [2][4];
   bit m_perm [2][4];
   int m_win  [2];
   int m_mode;
   bit m_ack;
   bit m_newf;

   function automatic void model_zero();
      for (int c = 0; c < 2; c++) begin
         m_win[c] = 0;
         for (int i = 0; i < 4; i++) begin
            m_cnt[c][i]  = 0;
            m_perm[c][i] = 1'b0;
         end
      end
   endfunction

   function automatic void model_reset();
      model_zero();
      m_mode = MODE_RUN;
      m_ack  = 1'b0;
      m_newf = 1'b0;
   endfunction

   function automatic void model_class(input int c, input bit v, input logic [3:0] m);
      bit decay;
      bit hit;
      decay = v && (m_win[c] == WINDOW - 1);
      if (v) m_win[c] = (m_win[c] + 1) % WINDOW;
      for (int i = 0; i < 4; i++) begin
         if (!m_perm[c][i]) begin
            hit = v && m[i];
            if (hit && decay) begin
               m_cnt[c][i] = m_cnt[c][i];
            end else if (hit) begin
               if (m_cnt[c][i] < CNT_MAX) m_cnt[c][i] = m_cnt[c][i] + 1;
            end else if (decay && m_cnt[c][i] > 0) begin
               m_cnt[c][i] = m_cnt[c][i] - 1;
            end
            if (m_cnt[c][i] >= THRESHOLD) begin
               m_perm[c][i] = 1'b1;
               m_newf       = 1'b1;
            end
         end
      end
   endfunction

   function automatic void model_update(input bit av, input logic [3:0] am,
                                        input bit mv, input logic [3:0] mm, input bit clr);
      m_newf = 1'b0;
      if (m_mode == MODE_RUN) begin
         model_class(0, av, am);
         model_class(1, mv, mm);
         if (clr) m_mode = MODE_CLEAR;
      end else if (m_mode == MODE_CLEAR) begin
         model_zero();
         m_mode = MODE_ACK;
         m_ack  = 1'b1;
      end else if (!clr) begin
         m_mode = MODE_RUN;
         m_ack  = 1'b0;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [3:0]  ep [2];
      logic [15:0] ec [2];
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < 4; i++) begin
            ep[c][i]          = m_perm[c][i];
            ec[c][i*4 +: 4]   = 4'(m_cnt[c][i]);
         end
      end
      chk({tag, "/perm_alu"},  32'(bus.permanent_faulty_alu_o),  32'(ep[0]));
      chk({tag, "/perm_mult"}, 32'(bus.permanent_faulty_mult_o), 32'(ep[1]));
      chk({tag, "/cnt_alu"},   32'(bus.err_cnt_alu_o),           32'(ec[0]));
      chk({tag, "/cnt_mult"},  32'(bus.err_cnt_mult_o),          32'(ec[1]));
      chk({tag, "/new_fault"}, 32'(bus.new_fault_o),             32'(m_newf));
      chk({tag, "/clr_ack"},   32'(bus.clr_ack_o),               32'(m_ack));
   endtask

   task automatic step(input string tag, input bit av, input logic [3:0] am,
                       input bit mv, input logic [3:0] mm, input bit clr);
      bus.alu_valid_i     = av;
      bus.alu_mismatch_i  = am;
      bus.mult_valid_i    = mv;
      bus.mult_mismatch_i = mm;
      bus.clr_req_i       = clr;
      @(posedge clk);
      model_update(av, am, mv, mm, clr);
      #1;
      check_all(tag);
   endtask

   initial begin
      int nf;
      bit clr;
      rst_n = 1'b1;
      bus.alu_valid_i = 1'b0;  bus.alu_mismatch_i  = 4'h0;
      bus.mult_valid_i = 1'b0; bus.mult_mismatch_i = 4'h0;
      bus.clr_req_i = 1'b0;
`ifdef CV32E40P_FT_FAULT_INJECT_EN
      bus.force_alu_i  = 4'h0;
      bus.force_mult_i = 4'h0;
`endif
      #2 rst_n = 1'b0;
      model_reset();
      @(posedge clk); #1;
      check_all("reset");
      @(negedge clk) rst_n = 1'b1;

      // ALU1 reaches threshold after 8 hits; exactly one new-fault pulse
      nf = 0;
      for (int k = 0; k < 8; k++) begin
         step("t1", 1'b1, 4'b0010, 1'b0, 4'h0, 1'b0);
         chk("t1_cnt1", 32'(bus.err_cnt_alu_o[7:4]), 32'(k + 1));
         nf += int'(bus.new_fault_o);
      end
      chk("t1_perm", 32'(bus.permanent_faulty_alu_o), 32'h2);
      step("t1_idle", 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
      nf += int'(bus.new_fault_o);
      chk("t1_pulses", 32'(nf), 32'd1);

      // MULT0 and MULT2 latch together, counters then freeze
      for (int k = 0; k < 11; k++) step("t4", 1'b0, 4'h0, 1'b1, 4'b0101, 1'b0);
      chk("t4_perm", 32'(bus.permanent_faulty_mult_o), 32'h5);
      chk("t4_cnt",  32'(bus.err_cnt_mult_o), 32'h0808);

      // Clear handshake; mismatches during CLEAR/ACK ignored
      step("t5_req",   1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      step("t5_clear", 1'b1, 4'hF, 1'b1, 4'hF, 1'b1);
      chk("t5_ack", 32'(bus.clr_ack_o), 32'd1);
      chk("t5_zero", 32'({bus.permanent_faulty_alu_o, bus.permanent_faulty_mult_o}), 32'h0);
      step("t5_ack",   1'b1, 4'hF, 1'b1, 4'hF, 1'b1);
      step("t5_drop",  1'b1, 4'hF, 1'b1, 4'hF, 1'b0);
      chk("t5_ack_low", 32'(bus.clr_ack_o), 32'd0);

      // 16 ops, ALU0 hit on ops 1,5,9,13, decay on op 16 -> 3
      for (int k = 1; k <= 16; k++)
         step("t2", 1'b1, ((k % 4) == 1) ? 4'b0001 : 4'b0000, 1'b0, 4'h0, 1'b0);
      chk("t2_cnt0", 32'(bus.err_cnt_alu_o[3:0]), 32'd3);
      chk("t2_perm", 32'(bus.permanent_faulty_alu_o), 32'h0);

      // Hit on the decay op itself leaves cnt0 unchanged
      for (int k = 17; k <= 31; k++) step("t3", 1'b1, 4'h0, 1'b0, 4'h0, 1'b0);
      step("t3_decay", 1'b1, 4'b0001, 1'b0, 4'h0, 1'b0);
      chk("t3_cnt0", 32'(bus.err_cnt_alu_o[3:0]), 32'd3);

      // Triggering hit coincident with clear request: fault shows, then wiped
      for (int k = 0; k < 7; k++) step("tc", 1'b1, 4'b0100, 1'b0, 4'h0, 1'b0);
      step("tc_trig", 1'b1, 4'b0100, 1'b0, 4'h0, 1'b1);
      chk("tc_perm", 32'(bus.permanent_faulty_alu_o), 32'h4);
      step("tc_clear", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      step("tc_ack",   1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

      // Reset during ACK
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("t6_rst");
      @(negedge clk) rst_n = 1'b1;
      bus.clr_req_i = 1'b0;
      step("t6_run", 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b0);
      chk("t6_track", 32'(bus.err_cnt_alu_o[15:12]), 32'd1);

      // Randomized traffic
      for (int k = 0; k < 1500; k++) begin
         logic [3:0] am;
         logic [3:0] mm;
         if (k < 750) begin
            am = 4'($urandom & $urandom & $urandom);
            mm = 4'($urandom & $urandom & $urandom);
         end else begin
            am = 4'($urandom);
            mm = 4'($urandom & $urandom);
         end
         if (m_mode == MODE_RUN) clr = ($urandom_range(0, 59) == 0);
         else                    clr = ($urandom_range(0, 3) != 0);
         step("rand", 1'($urandom), am, 1'($urandom), mm, clr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
